// File: rtl/alu_seq_unit.sv
// Handshaked 4-bit ALU that accepts one operation at a time and returns one result.
// Shift and multiply iterate for one step per cycle; every other op completes in the accept cycle.
module alu_seq_unit #(
    parameter int WIDTH      = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             busy
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state;
    logic               is_mul;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   shv;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   quick_y;
    logic               quick_c;
    logic               needs_exec;
    logic [2*WIDTH-1:0] mul_next;
    logic               last_step;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        quick_y = '0;
        quick_c = 1'b0;
        case (sel)
            OP_ADD: begin
                quick_y = sum[WIDTH-1:0];
                quick_c = sum[WIDTH];
            end
            OP_SUB: begin
                quick_y = a - b;
                quick_c = (a < b);
            end
            OP_AND: quick_y = a & b;
            OP_OR:  quick_y = a | b;
            OP_XOR: quick_y = a ^ b;
            OP_NOT: quick_y = ~a;
            // Only a zero shift amount completes here; it passes a through.
            OP_SHL: quick_y = a;
            default: quick_y = '0;
        endcase
    end

    assign needs_exec = (sel == OP_MUL) || ((sel == OP_SHL) && (b[1:0] != 2'b00));
    assign mul_next   = acc + (mplier[0] ? mcand : '0);
    assign last_step  = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            y         <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            is_mul    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            shv       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        is_mul   <= (sel == OP_MUL);
                        acc      <= '0;
                        mcand    <= {{WIDTH{1'b0}}, a};
                        mplier   <= b;
                        shv      <= a;
                        if (needs_exec) begin
                            state <= EXEC;
                            cnt   <= (sel == OP_MUL) ? CW'(MUL_CYCLES) : CW'(b[1:0]);
                        end else begin
                            state     <= DONE;
                            y         <= quick_y;
                            carry     <= quick_c;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    // Both iterators advance every cycle; is_mul picks which one feeds the result.
                    cnt    <= cnt - CW'(1);
                    acc    <= mul_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    shv    <= shv << 1;
                    if (last_step) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        if (is_mul) begin
                            y     <= mul_next[WIDTH-1:0];
                            carry <= |mul_next[2*WIDTH-1:WIDTH];
                        end else begin
                            y     <= shv << 1;
                            carry <= shv[WIDTH-1];
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_unit.sv
// Bench for alu_seq_unit: directed vector table, hand-written handshake/reset sequences,
// and random operations compared against an arithmetic reference model.
module tb_alu_seq_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] y;
    logic       carry;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_seq_unit #(.WIDTH(4), .MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .carry(carry), .busy(busy)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
        int         y;
        int         c;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: results from plain integer arithmetic; lat = cycles spent in EXEC.
    function automatic void model(input int ma, input int mb, input int msel,
                                  output int ey, output int ec, output int elat);
        int n;
        int p;
        n    = mb % 4;
        ec   = 0;
        elat = 0;
        p    = 0;
        case (msel)
            0: begin p = ma + mb; ey = p % 16; ec = (p > 15) ? 1 : 0; end
            1: begin ey = (ma - mb + 16) % 16; ec = (ma < mb) ? 1 : 0; end
            2: ey = ma & mb;
            3: ey = ma | mb;
            4: ey = ma ^ mb;
            5: ey = 15 - ma;
            6: begin
                p    = ma * (1 << n);
                ey   = p % 16;
                ec   = (n == 0) ? 0 : (ma >> (4 - n)) % 2;
                elat = n;
            end
            default: begin
                p    = ma * mb;
                ey   = p % 16;
                ec   = (p > 15) ? 1 : 0;
                elat = 4;
            end
        endcase
    endfunction

    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic [2:0] isel);
        @(negedge clk);
        check("in_ready_before_issue", in_ready, 1);
        a         = ia;
        b         = ib;
        sel       = isel;
        in_valid  = 1'b1;
        out_ready = 1'($urandom);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 4'($urandom);
        b         = 4'($urandom);
        sel       = 3'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("exec_busy", busy, 1);
            check("exec_in_ready", in_ready, 0);
            out_ready = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        out_ready = 1'b0;
    endtask

    task automatic expect_result(input string name, input int ey, input int ec,
                                 input int elat, input int lat);
        check({name, "_lat"}, lat, elat);
        check({name, "_y"}, y, ey);
        check({name, "_carry"}, carry, ec);
        check({name, "_done_busy"}, busy, 1);
        check({name, "_done_in_ready"}, in_ready, 0);
    endtask

    task automatic handoff(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_post_out_valid"}, out_valid, 0);
        check({name, "_post_in_ready"}, in_ready, 1);
        check({name, "_post_busy"}, busy, 0);
    endtask

    task automatic run_op(input string name, input logic [3:0] ia, input logic [3:0] ib,
                          input logic [2:0] isel, input int ey, input int ec,
                          input int elat, input int hold);
        int lat;
        issue(ia, ib, isel);
        wait_done(lat);
        expect_result(name, ey, ec, elat, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, out_valid, 1);
            check({name, "_hold_y"}, y, ey);
        end
        handoff(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int ey, ec, elat;
        logic [3:0] ra, rb;
        logic [2:0] rsel;

        vecs[0] = '{a: 4'b1100, b: 4'b1010, sel: 3'b000, y: 6,  c: 1, lat: 0};
        vecs[1] = '{a: 4'b0100, b: 4'b1010, sel: 3'b001, y: 10, c: 1, lat: 0};
        vecs[2] = '{a: 4'b1010, b: 4'b0100, sel: 3'b111, y: 8,  c: 1, lat: 4};
        vecs[3] = '{a: 4'b1010, b: 4'b0010, sel: 3'b110, y: 8,  c: 0, lat: 2};
        vecs[4] = '{a: 4'b1011, b: 4'b1100, sel: 3'b110, y: 11, c: 0, lat: 0};
        vecs[5] = '{a: 4'b1001, b: 4'b0011, sel: 3'b110, y: 8,  c: 0, lat: 3};
        vecs[6] = '{a: 4'b0110, b: 4'b0001, sel: 3'b101, y: 9,  c: 0, lat: 0};
        vecs[7] = '{a: 4'b1100, b: 4'b0101, sel: 3'b011, y: 13, c: 0, lat: 0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_y", y, 0);
        check("reset_carry", carry, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sel,
                   vecs[i].y, vecs[i].c, vecs[i].lat, 0);

        // Backpressure, with a new request held up while the result waits.
        issue(4'b1010, 4'b0100, 3'b100);
        wait_done(lat);
        expect_result("bp_xor", 14, 0, 0, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a = 4'b0001; b = 4'b0001; sel = 3'b000; in_valid = 1'b1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_y", y, 14);
            check("bp_hold_carry", carry, 0);
            check("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_in_ready", in_ready, 1);
        check("bp_idle_out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        expect_result("bp_next_add", 2, 0, 0, lat);
        handoff("bp_next_add");

        // Reset during the second EXEC cycle of a multiply.
        issue(4'b0011, 4'b0101, 3'b111);
        @(negedge clk);
        check("rst_mid_exec_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_y", y, 0);
        check("rst_mid_carry", carry, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_in_ready", in_ready, 1);
        repeat (5) begin
            @(negedge clk);
            check("rst_mid_stays_idle", out_valid, 0);
        end
        run_op("post_rst_add", 4'b0001, 4'b0001, 3'b000, 2, 0, 0, 0);

        // Operands changing after accept must not disturb the held result.
        issue(4'b1010, 4'b0100, 3'b010);
        wait_done(lat);
        expect_result("opchg_and", 0, 0, 0, lat);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 4'b1111; b = 4'b1111; sel = 3'b011;
            check("opchg_hold_y", y, 0);
            check("opchg_hold_carry", carry, 0);
        end
        handoff("opchg_and");

        for (int i = 0; i < 150; i++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rsel = 3'($urandom_range(0, 7));
            model(int'(ra), int'(rb), int'(rsel), ey, ec, elat);
            run_op($sformatf("rnd%0d_sel%0d_a%0d_b%0d", i, rsel, ra, rb),
                   ra, rb, rsel, ey, ec, elat, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
